// File: rtl/shift_word_feeder.sv
// Buffers parallel words in a small FIFO and serialises each one onto the serial
// input of a universal shift register, MSB first for left shifts and LSB first for right shifts.
module shift_word_feeder #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    input  logic                           in_dir,
    input  logic                           flush,
    output logic                           shift_enable,
    output logic                           shift_left,
    output logic                           shift_right,
    output logic                           data_bit,
    output logic                           busy,
    output logic                           word_done,
    output logic [$clog2(DEPTH+1)-1:0]     fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [WIDTH:0]     mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   count_q;
    logic [WIDTH-1:0]   sbuf;
    logic               dir_q;
    logic [BIT_W-1:0]   bit_cnt;
    logic [WIDTH:0]     head;
    logic               push, pop;

    assign in_ready   = (count_q < CNT_W'(DEPTH));
    assign fifo_count = count_q;
    assign head       = mem[rd_ptr];
    assign push       = in_valid & in_ready & ~flush;
    assign pop        = ~flush & (count_q != '0) & ((state_q == IDLE) | (state_q == DONE));

    // Word storage is pure data and is never cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_dir, in_data};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            sbuf    <= '0;
            dir_q   <= 1'b0;
            bit_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (flush) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                count_q <= '0;
                bit_cnt <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop) begin
                    rd_ptr  <= rd_ptr + 1'b1;
                    sbuf    <= head[WIDTH-1:0];
                    dir_q   <= head[WIDTH];
                    bit_cnt <= '0;
                end else if (state_q == SHIFT) begin
                    // Move the next bit toward the end being emitted.
                    sbuf    <= dir_q ? {1'b0, sbuf[WIDTH-1:1]} : {sbuf[WIDTH-2:0], 1'b0};
                    bit_cnt <= bit_cnt + 1'b1;
                end
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        shift_enable = 1'b0;
        word_done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) state_d = SHIFT;
            end
            SHIFT: begin
                shift_enable = 1'b1;
                if (bit_cnt == BIT_W'(WIDTH-1)) state_d = DONE;
            end
            DONE: begin
                word_done = 1'b1;
                state_d   = pop ? SHIFT : IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    assign busy        = (state_q != IDLE);
    assign shift_left  = shift_enable & ~dir_q;
    assign shift_right = shift_enable & dir_q;
    assign data_bit    = shift_enable & (dir_q ? sbuf[0] : sbuf[WIDTH-1]);

endmodule

// File: tb/tb_shift_word_feeder.sv
// Scoreboard bench for shift_word_feeder with a model of the downstream 8-bit shift register.
module tb_shift_word_feeder;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic       flush;
    logic       shift_enable, shift_left, shift_right, data_bit, busy, word_done;
    logic [2:0] fifo_count;

    logic [7:0] dreg;
    logic [8:0] sb[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         done_cnt = 0;

    shift_word_feeder #(.WIDTH(8), .DEPTH(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dir(in_dir), .flush(flush),
        .shift_enable(shift_enable), .shift_left(shift_left), .shift_right(shift_right),
        .data_bit(data_bit), .busy(busy), .word_done(word_done), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Downstream universal shift register, reset to 0 and enabled only by the feeder.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)         dreg <= 8'h00;
        else if (shift_left)  dreg <= {dreg[6:0], data_bit};
        else if (shift_right) dreg <= {data_bit, dreg[7:1]};
    end

    // One clock: record accepted words, advance, then pop the scoreboard on word_done.
    task automatic cycle(output bit acc);
        logic [8:0] e;
        acc = in_valid && in_ready && !flush;
        if (flush) sb.delete();
        if (acc) sb.push_back({in_dir, in_data});
        @(posedge clk); #1;
        if (word_done) begin
            done_cnt++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL word_done_unexpected: got pulse, expected none (scoreboard empty)");
            end else begin
                e = sb.pop_front();
                if (dreg !== e[7:0]) begin
                    n_fail++;
                    $display("FAIL register_value: got %02h, expected %02h", dreg, e[7:0]);
                end
            end
        end
    endtask

    task automatic send_and_check(input logic [7:0] w, input logic d);
        bit acc;
        in_valid = 1'b1; in_data = w; in_dir = d;
        cycle(acc);
        in_valid = 1'b0;
        n_checks++;
        if (!acc || fifo_count !== 3'd1 || shift_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_%02h: got acc=%0d count=%0d se=%0d, expected 1 1 0", w, acc, fifo_count, shift_enable);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(acc);
            n_checks++;
            if (shift_enable !== 1'b1 || shift_left !== ~d || shift_right !== d || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL shift_ctl_%02h[%0d]: got se=%0d l=%0d r=%0d busy=%0d, expected 1 %0d %0d 1",
                         w, i, shift_enable, shift_left, shift_right, busy, ~d, d);
            end
            n_checks++;
            if (data_bit !== (d ? w[i] : w[7-i])) begin
                n_fail++;
                $display("FAIL data_bit_%02h[%0d]: got %0d, expected %0d", w, i, data_bit, d ? w[i] : w[7-i]);
            end
        end
        cycle(acc);
        n_checks++;
        if (word_done !== 1'b1 || shift_enable !== 1'b0 || data_bit !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL done_%02h: got wd=%0d se=%0d bit=%0d busy=%0d, expected 1 0 0 1",
                     w, word_done, shift_enable, data_bit, busy);
        end
        cycle(acc);
        n_checks++;
        if (word_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_%02h: got wd=%0d busy=%0d, expected 0 0", w, word_done, busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_dir = 1'b0; flush = 1'b0;
        #3;
        n_checks++;
        if ({shift_enable, shift_left, shift_right, data_bit, busy, word_done} !== 6'b0 ||
            in_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got outs=%06b ready=%0d count=%0d, expected 000000 1 0",
                     {shift_enable, shift_left, shift_right, data_bit, busy, word_done}, in_ready, fifo_count);
        end
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_left();
        send_and_check(8'hDB, 1'b0);
    endtask

    task automatic test_single_right();
        send_and_check(8'h32, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [8:0] bb [3];
        bit acc, prev_se;
        int se_total, rises, gap;
        bb[0] = {1'b0, 8'hAA}; bb[1] = {1'b1, 8'h55}; bb[2] = {1'b0, 8'hF0};
        done_cnt = 0; se_total = 0; rises = 0; gap = 0; prev_se = 1'b0;
        for (int k = 0; k < 45; k++) begin
            if (k < 3) begin
                in_valid = 1'b1; {in_dir, in_data} = bb[k];
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc);
            if (k < 3) begin
                n_checks++;
                if (!acc) begin
                    n_fail++;
                    $display("FAIL b2b_accept[%0d]: got 0, expected 1", k);
                end
            end
            if (shift_enable) begin
                se_total++;
                if (!prev_se) begin
                    rises++;
                    if (rises > 1) begin
                        n_checks++;
                        if (gap != 1) begin
                            n_fail++;
                            $display("FAIL b2b_gap: got %0d idle cycles, expected 1", gap);
                        end
                    end
                end
                gap = 0;
            end else begin
                gap++;
            end
            prev_se = shift_enable;
        end
        n_checks++;
        if (se_total != 24 || rises != 3 || done_cnt != 3) begin
            n_fail++;
            $display("FAIL b2b_totals: got shifts=%0d bursts=%0d dones=%0d, expected 24 3 3", se_total, rises, done_cnt);
        end
    endtask

    task automatic test_fifo_full();
        bit acc;
        int idx;
        logic [7:0] w;
        done_cnt = 0; idx = 0;
        for (int k = 0; k < 300 && (idx < 6 || sb.size() != 0); k++) begin
            w = 8'h3C + 8'(17 * idx);
            if (idx < 6) begin
                in_valid = 1'b1; in_data = w; in_dir = idx[0];
            end else begin
                in_valid = 1'b0;
            end
            cycle(acc);
            if (acc) idx++;
            if (acc && idx == 5) begin
                n_checks++;
                if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL fifo_full: got count=%0d ready=%0d, expected 4 0", fifo_count, in_ready);
                end
            end
            if (fifo_count > 3'd4) begin
                n_checks++;
                n_fail++;
                $display("FAIL fifo_overflow: got count=%0d, expected at most 4", fifo_count);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (idx != 6 || sb.size() != 0 || done_cnt != 6) begin
            n_fail++;
            $display("FAIL fifo_drain: got accepted=%0d pending=%0d dones=%0d, expected 6 0 6", idx, sb.size(), done_cnt);
        end
        repeat (2) cycle(acc);
    endtask

    task automatic test_flush_mid_word();
        bit acc;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 8'hA0 + 8'(k); in_dir = 1'b0;
            cycle(acc);
        end
        in_valid = 1'b0;
        repeat (2) cycle(acc);
        n_checks++;
        if (shift_enable !== 1'b1 || fifo_count !== 3'd2) begin
            n_fail++;
            $display("FAIL flush_setup: got se=%0d count=%0d, expected 1 2", shift_enable, fifo_count);
        end
        flush = 1'b1; in_valid = 1'b1; in_data = 8'h77;
        cycle(acc);
        flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (shift_enable !== 1'b0 || busy !== 1'b0 || fifo_count !== 3'd0 || word_done !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_state: got se=%0d busy=%0d count=%0d wd=%0d, expected 0 0 0 0",
                     shift_enable, busy, fifo_count, word_done);
        end
        done_cnt = 0;
        repeat (20) cycle(acc);
        n_checks++;
        if (done_cnt != 0 || fifo_count !== 3'd0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_quiet: got dones=%0d count=%0d busy=%0d, expected 0 0 0", done_cnt, fifo_count, busy);
        end
    endtask

    task automatic test_reset_mid_word();
        bit acc;
        in_valid = 1'b1; in_data = 8'hC3; in_dir = 1'b1;
        cycle(acc);
        in_valid = 1'b0;
        repeat (4) cycle(acc);
        n_checks++;
        if (shift_enable !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_setup: got se=%0d, expected 1", shift_enable);
        end
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if (shift_enable !== 1'b0 || busy !== 1'b0 || word_done !== 1'b0 ||
            in_ready !== 1'b1 || fifo_count !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset: got se=%0d busy=%0d wd=%0d ready=%0d count=%0d, expected 0 0 0 1 0",
                     shift_enable, busy, word_done, in_ready, fifo_count);
        end
        sb.delete();
        @(negedge clk);
        @(negedge clk); reset_n = 1'b1;
        @(posedge clk); #1;
        send_and_check(8'h81, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_left();
        test_single_right();
        test_back_to_back();
        test_fifo_full();
        test_flush_mid_word();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/shift_word_feeder.md
Name: shift_word_feeder

Overview:
- Upstream stage of the 8-bit universal shift register. Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Serialises each word onto the register's serial input. Drives shift_enable, shift_left and shift_right so the register holds exactly the submitted word after WIDTH shifts.
- Per-word direction: left = MSB first, right = LSB first. Pulses word_done when a word has been fully delivered.

Parameters:
- WIDTH, 8: bits per word; must equal the downstream register width.
- DEPTH, 4: FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  FIFO can accept a word; equals (fifo_count < DEPTH).
- in_data  in  WIDTH  word to serialise.
- in_dir  in  1  0 = shift left (MSB first), 1 = shift right (LSB first); stored with the word.
- flush  in  1  synchronous abort: empties the FIFO and drops the word in flight.
- shift_enable  out  1  high on every shift cycle.
- shift_left  out  1  shift_enable & ~dir of the active word.
- shift_right  out  1  shift_enable & dir of the active word.
- data_bit  out  1  serial bit to the register's data_in.
- busy  out  1  high in SHIFT or DONE.
- word_done  out  1  one-cycle pulse after the last bit of a word.
- fifo_count  out  clog2(DEPTH+1)  words currently buffered.

Behaviour:
- Reset (reset_n low, asynchronous):
  - FIFO pointers and count go to 0; state goes to IDLE; shift buffer, bit counter and active dir go to 0.
  - All outputs are 0 except in_ready, which is 1.
  - Outputs drop on reset assertion without waiting for a clock edge.
  - A word in flight is lost and no word_done is produced.
- FIFO push: on in_valid & in_ready, {in_dir, in_data} is written. If the FIFO is full, in_valid is ignored.
- FIFO pop: only from IDLE or DONE.
  - Push and pop in the same cycle leave fifo_count unchanged.
  - Push into a full FIFO in the same cycle as a pop is not accepted, because in_ready is computed from the registered count.
- FSM states:
  - IDLE: outputs low. If fifo_count != 0, pop the head into the shift buffer and active dir, clear the bit counter, and go to SHIFT.
  - SHIFT:
    - shift_enable = 1.
    - data_bit = buf[WIDTH-1] when dir = 0, buf[0] when dir = 1.
    - At each edge the buffer shifts toward the emitted end and the counter increments.
    - After WIDTH SHIFT cycles, go to DONE.
  - DONE: shift_enable = 0 and word_done = 1 for exactly one cycle.
    - If the FIFO is non-empty, pop and go to SHIFT.
    - Otherwise go to IDLE.
- Latency, word accepted into an empty idle block at edge t:
  - Pop at edge t+1.
  - SHIFT cycles t+2 … t+WIDTH+1.
  - word_done during cycle t+WIDTH+2.
- Throughput: back-to-back words take WIDTH+1 cycles each (one DONE gap).
- data_bit, shift_left and shift_right are 0 whenever shift_enable is 0.
- flush: at the next edge the FIFO empties and the state goes to IDLE with no word_done.
  - A word presented in the same cycle as flush is dropped.
  - flush has priority over push, pop and FSM advance.
- Result on the downstream register (reset to 0, enabled only by this block): after a word's WIDTH shifts it equals in_data, for either direction.

Test Plan:
- Single left word: push 0xDB with dir = 0 → data_bit sequence 1,1,0,1,1,0,1,1 and shift_left high for 8 cycles. Register reads 0xDB; word_done occurs 10 cycles after acceptance.
- Single right word: push 0x32 with dir = 1 → data_bit sequence 0,1,0,0,1,1,0,0 and shift_right high. Register reads 0x32.
- Back-to-back: push 0xAA (dir 0), 0x55 (dir 1), 0xF0 (dir 0) consecutively → three 8-cycle bursts separated by a single DONE cycle. Register reads each value at its word_done; exactly 3 pulses.
- FIFO full: hold in_valid for 6 consecutive words while the first shifts → in_ready drops when fifo_count reaches 4. Stalled words are accepted later in order; no loss or duplication.
- Flush mid-word: assert flush on the 4th SHIFT cycle with 2 words queued → next cycle state is IDLE, fifo_count = 0, shift_enable = 0. No word_done pulse follows.
- Reset mid-word: drop reset_n asynchronously mid-SHIFT → shift_enable, busy and word_done go to 0 immediately and in_ready goes to 1. After release, a new push of 0x81 serialises correctly.
